// File: rtl/shutter_pkg.sv
// shutter_pkg: shared FSM states, shutter status codes and trigger source encodings.
package shutter_pkg;
  typedef enum logic [2:0] {IDLE, CLOSING, SETTLE_C, HOLD, OPENING, SETTLE_O} state_t;
  localparam logic [1:0] SHUTTER_OPEN = 2'b01;
  localparam logic [1:0] SHUTTER_CLOS = 2'b10;
  localparam logic [1:0] SHUTTER_MOVE = 2'b00;
  localparam logic [1:0] TRIG_STARTUP = 2'd0;
  localparam logic [1:0] TRIG_MANUAL  = 2'd1;
  localparam logic [1:0] TRIG_TEMP    = 2'd2;
  localparam logic [1:0] TRIG_AUTO    = 2'd3;
  function automatic logic [1:0] status_of(input state_t s);
    return s == IDLE ? SHUTTER_OPEN : s == HOLD ? SHUTTER_CLOS : SHUTTER_MOVE;
  endfunction
endpackage

// File: rtl/shutter_trig_arb.sv
// shutter_trig_arb: pending flags, sec counter, temp drift compare and priority encoder feeding the shutter FSM.
module shutter_trig_arb
  import shutter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        idle,
  input  logic        sec_tick,
  input  logic        manual_req,
  input  logic        auto_en,
  input  logic [15:0] auto_period,
  input  logic [15:0] temp,
  input  logic [15:0] temp_pre,
  input  logic [15:0] delta_th,
  output logic        valid,
  output logic [1:0]  src
);
  logic [15:0] sec_cnt;
  logic [16:0] diff;
  logic        man_pend, start_pend;
  logic        man_hit, temp_hit, auto_hit;
  assign man_hit  = manual_req | man_pend;
  assign temp_hit = delta_th != 16'd0 && diff > {1'b0, delta_th};
  assign auto_hit = auto_en && auto_period != 16'd0 && sec_cnt >= auto_period;
  assign valid    = idle & (start_pend | man_hit | temp_hit | auto_hit);
  assign src      = start_pend ? TRIG_STARTUP : man_hit ? TRIG_MANUAL : temp_hit ? TRIG_TEMP : TRIG_AUTO;
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_cnt    <= '0;
      diff       <= '0;
      man_pend   <= 1'b0;
      start_pend <= 1'b1;
    end else begin
      diff       <= temp >= temp_pre ? {1'b0, temp} - {1'b0, temp_pre} : {1'b0, temp_pre} - {1'b0, temp};
      sec_cnt    <= valid ? '0 : (idle && auto_en && sec_tick && sec_cnt != 16'hFFFF) ? sec_cnt + 16'd1 : sec_cnt;
      start_pend <= start_pend & ~valid;
      // requests arriving while busy merge into one pending cycle
      man_pend   <= (valid && src == TRIG_MANUAL) ? 1'b0 : man_pend | manual_req;
    end
  end
endmodule

// File: rtl/shutter_ctrl.sv
// shutter_ctrl: shutter close/hold/open sequencer with calibration window.
// Optional HOLD watchdog enabled by defining SHUTTER_HOLD_TIMEOUT_EN.
module shutter_ctrl
  import shutter_pkg::*;
#(
  parameter int PULSE_CYC        = 20000,
  parameter int SETTLE_CYC       = 5000,
  parameter int CLOSED_FRAMES    = 4,
  parameter int HOLD_TIMEOUT_CYC = 2000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sec_tick,
  input  logic        i_frame_start,
  input  logic        i_manual_req,
  input  logic        i_auto_en,
  input  logic [15:0] i_auto_period,
  input  logic [15:0] i_temp_sensor,
  input  logic [15:0] i_temp_sensor_pre,
  input  logic [15:0] i_temp_delta_th,
  output logic [1:0]  o_shutter,
  output logic        o_motor_close,
  output logic        o_motor_open,
  output logic        o_calib_win,
  output logic        o_busy,
  output logic [1:0]  o_trig_src,
  output logic        o_err
);
  localparam int NF = CLOSED_FRAMES == 0 ? 1 : CLOSED_FRAMES;
  localparam int CW = $clog2((PULSE_CYC > SETTLE_CYC ? PULSE_CYC : SETTLE_CYC) + 1);
  localparam int FW = $clog2(NF + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [FW-1:0] F_LAST = FW'(NF - 1);
  state_t          state, nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [FW-1:0]   fc;
  logic            trig_valid, done, timeout;
  logic [1:0]      trig_src;
  shutter_trig_arb u_arb (
    .clk        (i_clk),
    .rst        (i_rst),
    .idle       (state == IDLE),
    .sec_tick   (i_sec_tick),
    .manual_req (i_manual_req),
    .auto_en    (i_auto_en),
    .auto_period(i_auto_period),
    .temp       (i_temp_sensor),
    .temp_pre   (i_temp_sensor_pre),
    .delta_th   (i_temp_delta_th),
    .valid      (trig_valid),
    .src        (trig_src)
  );
  assign done = state == HOLD && i_frame_start && fc == F_LAST;
`ifdef SHUTTER_HOLD_TIMEOUT_EN
  localparam int TW = $clog2(HOLD_TIMEOUT_CYC + 1);
  logic [TW-1:0] hc;
  logic          err;
  assign timeout = state == HOLD && !i_frame_start && hc == TW'(HOLD_TIMEOUT_CYC - 1);
  assign o_err   = err;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hc  <= '0;
      err <= 1'b0;
    end else begin
      hc  <= (state == HOLD && !i_frame_start) ? hc + 1'b1 : '0;
      err <= err | timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = trig_valid ? CLOSING : IDLE;
      CLOSING:  nxt = cnt == P_LAST ? SETTLE_C : CLOSING;
      SETTLE_C: nxt = cnt == S_LAST ? HOLD : SETTLE_C;
      HOLD:     nxt = (done | timeout) ? OPENING : HOLD;
      OPENING:  nxt = cnt == P_LAST ? SETTLE_O : OPENING;
      SETTLE_O: nxt = cnt == S_LAST ? IDLE : SETTLE_O;
      default:  nxt = IDLE;
    endcase
    // one counter serves every timed state; it restarts on each state change
    cnt_nxt = (nxt != state || state == IDLE || state == HOLD) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      fc            <= '0;
      o_shutter     <= SHUTTER_OPEN;
      o_motor_close <= 1'b0;
      o_motor_open  <= 1'b0;
      o_calib_win   <= 1'b0;
      o_busy        <= 1'b0;
      o_trig_src    <= TRIG_STARTUP;
    end else begin
      state         <= nxt;
      cnt           <= cnt_nxt;
      fc            <= state == HOLD ? fc + FW'(i_frame_start) : '0;
      o_shutter     <= status_of(nxt);
      o_motor_close <= nxt == CLOSING;
      o_motor_open  <= nxt == OPENING;
      o_calib_win   <= nxt == HOLD;
      o_busy        <= nxt != IDLE;
      o_trig_src    <= trig_valid ? trig_src : o_trig_src;
    end
  end
endmodule

// File: tb/tb_shutter_ctrl.sv
// tb_shutter_ctrl: directed test of shutter_ctrl with PULSE_CYC=4, SETTLE_CYC=3, CLOSED_FRAMES=2.
module tb_shutter_ctrl;
  import shutter_pkg::*;
  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_sec_tick = 1'b0, i_frame_start = 1'b0, i_manual_req = 1'b0, i_auto_en = 1'b0;
  logic [15:0] i_auto_period = '0, i_temp_sensor = '0, i_temp_sensor_pre = '0, i_temp_delta_th = '0;
  logic [1:0]  o_shutter, o_trig_src;
  logic        o_motor_close, o_motor_open, o_calib_win, o_busy, o_err;
  int          checks = 0, errors = 0;
  localparam logic [5:0] IDLE_O  = 6'b01_0000;
  localparam logic [5:0] CLOSE_O = 6'b00_1001;
  localparam logic [5:0] SETL_O  = 6'b00_0001;
  localparam logic [5:0] HOLD_O  = 6'b10_0011;
  localparam logic [5:0] OPEN_O  = 6'b00_0101;
  wire [5:0] outs = {o_shutter, o_motor_close, o_motor_open, o_calib_win, o_busy};
  always #5 clk = ~clk;
  shutter_ctrl #(.PULSE_CYC(4), .SETTLE_CYC(3), .CLOSED_FRAMES(2), .HOLD_TIMEOUT_CYC(10)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_sec_tick(i_sec_tick), .i_frame_start(i_frame_start),
    .i_manual_req(i_manual_req), .i_auto_en(i_auto_en), .i_auto_period(i_auto_period),
    .i_temp_sensor(i_temp_sensor), .i_temp_sensor_pre(i_temp_sensor_pre), .i_temp_delta_th(i_temp_delta_th),
    .o_shutter(o_shutter), .o_motor_close(o_motor_close), .o_motor_open(o_motor_open),
    .o_calib_win(o_calib_win), .o_busy(o_busy), .o_trig_src(o_trig_src), .o_err(o_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic walk(input int n, input logic [5:0] exp, input string tag);
    repeat (n) begin
      tick();
      chk(tag, {26'd0, outs}, {26'd0, exp});
      chk({tag, "_excl"}, {31'd0, o_motor_close & o_motor_open}, 32'd0);
    end
  endtask
  // expects the trigger to be live now; closing starts at the next edge
  task automatic do_cycle(input logic [1:0] src, input bit man_hold, input bit man_open);
    walk(1, CLOSE_O, "close");
    i_manual_req = 1'b0;
    i_temp_delta_th = '0;
    walk(3, CLOSE_O, "close");
    walk(3, SETL_O, "settle_c");
    walk(1, HOLD_O, "hold");
    i_frame_start = 1'b1;
    i_manual_req = man_hold;
    walk(1, HOLD_O, "hold_f1");
    i_frame_start = 1'b0;
    i_manual_req = 1'b0;
    walk(2, HOLD_O, "hold");
    i_frame_start = 1'b1;
    walk(1, OPEN_O, "open");
    i_frame_start = 1'b0;
    i_manual_req = man_open;
    walk(1, OPEN_O, "open");
    i_manual_req = 1'b0;
    walk(2, OPEN_O, "open");
    walk(3, SETL_O, "settle_o");
    walk(1, IDLE_O, "idle");
    chk("trig_src", {30'd0, o_trig_src}, {30'd0, src});
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_outs", {26'd0, outs}, {26'd0, IDLE_O});
    chk("rst_src", {30'd0, o_trig_src}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    i_rst = 1'b0;
    do_cycle(TRIG_STARTUP, 1'b0, 1'b0);
    walk(3, IDLE_O, "idle_quiet");
    i_temp_sensor = 16'd1000;
    i_temp_sensor_pre = 16'd940;
    i_temp_delta_th = 16'd60;
    walk(3, IDLE_O, "temp_eq_th");
    i_temp_delta_th = 16'd0;
    walk(3, IDLE_O, "temp_th0");
    i_temp_delta_th = 16'd50;
    do_cycle(TRIG_TEMP, 1'b0, 1'b0);
    walk(2, IDLE_O, "after_temp");
    i_auto_en = 1'b1;
    i_auto_period = 16'd3;
    repeat (2) begin
      i_sec_tick = 1'b1;
      walk(1, IDLE_O, "auto_wait");
      i_sec_tick = 1'b0;
      walk(1, IDLE_O, "auto_wait");
    end
    i_sec_tick = 1'b1;
    walk(1, IDLE_O, "auto_tick3");
    i_sec_tick = 1'b0;
    do_cycle(TRIG_AUTO, 1'b0, 1'b0);
    i_auto_period = 16'd0;
    repeat (5) begin
      i_sec_tick = 1'b1;
      walk(1, IDLE_O, "auto_p0");
      i_sec_tick = 1'b0;
      walk(1, IDLE_O, "auto_p0");
    end
    i_auto_en = 1'b0;
    i_manual_req = 1'b1;
    do_cycle(TRIG_MANUAL, 1'b1, 1'b1);
    do_cycle(TRIG_MANUAL, 1'b0, 1'b0);
    walk(4, IDLE_O, "no_extra");
    i_manual_req = 1'b1;
    i_temp_delta_th = 16'd50;
    do_cycle(TRIG_MANUAL, 1'b0, 1'b0);
    walk(3, IDLE_O, "after_mixed");
    i_manual_req = 1'b1;
    walk(1, CLOSE_O, "pre_rst");
    i_manual_req = 1'b0;
    walk(1, CLOSE_O, "pre_rst");
    i_rst = 1'b1;
    walk(1, IDLE_O, "rst_mid");
    chk("rst_mid_src", {30'd0, o_trig_src}, 32'd0);
    i_rst = 1'b0;
    do_cycle(TRIG_STARTUP, 1'b0, 1'b0);
`ifdef SHUTTER_HOLD_TIMEOUT_EN
    i_manual_req = 1'b1;
    walk(1, CLOSE_O, "to_close");
    i_manual_req = 1'b0;
    walk(3, CLOSE_O, "to_close");
    walk(3, SETL_O, "to_settle");
    walk(10, HOLD_O, "to_hold");
    walk(1, OPEN_O, "to_open");
    chk("to_err_set", {31'd0, o_err}, 32'd1);
    walk(3, OPEN_O, "to_open");
    walk(3, SETL_O, "to_settle_o");
    walk(1, IDLE_O, "to_idle");
    chk("to_err_sticky", {31'd0, o_err}, 32'd1);
    i_rst = 1'b1;
    tick();
    chk("to_err_rst", {31'd0, o_err}, 32'd0);
    i_rst = 1'b0;
`else
    chk("err_tied", {31'd0, o_err}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
